exec_arbiter: RTL and testbench
===============================

// Module: exec_arbiter
// PURPOSE
// Shares the single combinational execution unit (ALU) between two requesters
// (port 0: EX stage, port 1: secondary requester, e.g. self-test/debug engine).
// Round-robin grant, valid/ready handshake per port, operands held stable for a
// parameterised ALU latency, and a registered result returned only to the owning port.
// PARAMETERS
// W        32  data width of d1/d2/imm/result
// CTRL_W    5  width of ALU control code (passed through, never decoded)
// ALU_LAT   1  cycles operands are held on alu_* before result capture (>=1)
// PORTS
// clk         in   1       clock, all state on rising edge
// rst_n       in   1       asynchronous, active-low reset
// r0_valid    in   1       port 0 request valid
// r0_ready    out  1       port 0 request accepted this cycle (when r0_valid)
// r0_d1/r0_d2 in   W       port 0 operands
// r0_imm      in   W       port 0 shift amount / immediate
// r0_ctrl     in   CTRL_W  port 0 ALU control code
// r1_*        --   --      same set of signals for port 1
// rsp0_valid  out  1       result valid for port 0
// rsp0_ready  in   1       port 0 consumes result
// rsp1_valid  out  1       result valid for port 1
// rsp1_ready  in   1       port 1 consumes result
// rsp_data    out  W       registered ALU result (shared, qualified by rspN_valid)
// rsp_zero    out  1       registered ALU zero flag
// alu_d1/alu_d2/alu_imm out W; alu_ctrl out CTRL_W: operands to ALU
// alu_result  in   W       ALU result;  alu_zero in 1: ALU zero flag
// busy        out  1       high in any state other than IDLE
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, all outputs 0, operand/result regs 0,
//   lat counter 0, last_grant=1 (port 0 wins first tie). In-flight op discarded.
// - FSM: IDLE -> EXEC on accept; EXEC -> RESP after ALU_LAT cycles;
//   RESP -> IDLE when owner's rspN_ready=1 (while rspN_valid=1).
// - Grant (combinational, IDLE only): one valid -> that port; both valid ->
//   port != last_grant. rN_ready=1 only in IDLE for the granted port; never both.
// - Accept = rN_valid & rN_ready: latch d1,d2,imm,ctrl, owner=N, last_grant=N.
// - Requesters hold valid+payload stable until accepted; payload changes before
//   accept are legal, latched value is the one present at the accept edge.
// - alu_* driven from latched operand regs at all times (stable through EXEC).
// - EXEC: counter counts ALU_LAT cycles; on last cycle capture alu_result and
//   alu_zero into rsp_data/rsp_zero, go RESP.
// - Latency: accept at edge T -> rspN_valid high from T+ALU_LAT+1.
//   Minimum issue interval ALU_LAT+2 cycles (no accept in RESP).
// - RESP: only owner's rspN_valid high; rsp_data/rsp_zero held until handshake;
//   other port's requests wait (ready=0); non-owner rsp_ready ignored.
// - Fairness: with both ports continuously valid, grants strictly alternate.
// - ctrl codes not decoded; unknown codes produce whatever ALU returns.
// TESTING
// - p0 add 5+3 (ctrl 00010), rsp0_ready=1, ALU_LAT=1 -> rsp0_valid at T+2, data=8, zero=0.
// - p0 & p1 valid same cycle, always -> grants p0,p1,p0,p1; each rsp to correct port only.
// - p1 sub 7-7 (ctrl 00110) -> rsp1_valid, data=0, rsp_zero=1; rsp0_valid stays 0.
// - rsp0_ready low 5 cycles -> rsp_data stable, busy=1, r1_ready=0; release -> IDLE.
// - rst_n pulled low mid-EXEC -> all outputs 0 immediately; after release p0 wins tie.
// - ALU_LAT=3, alu_* checked stable 3 cycles -> rsp0_valid at T+4 with captured result.

Source files
------------

// File: rtl/exec_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are latched on accept, held for ALU_LAT cycles, and the registered result goes back to the owner.
module exec_arbiter #(
  parameter int W       = 32,
  parameter int CTRL_W  = 5,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [W-1:0]      r0_d1,
  input  logic [W-1:0]      r0_d2,
  input  logic [W-1:0]      r0_imm,
  input  logic [CTRL_W-1:0] r0_ctrl,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [W-1:0]      r1_d1,
  input  logic [W-1:0]      r1_d2,
  input  logic [W-1:0]      r1_imm,
  input  logic [CTRL_W-1:0] r1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_zero,
  output logic [W-1:0]      alu_d1,
  output logic [W-1:0]      alu_d2,
  output logic [W-1:0]      alu_imm,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     lat_cnt_reg, lat_cnt_next;
  logic              last_grant_reg;
  logic              owner_reg;
  logic [W-1:0]      d1_reg, d2_reg, imm_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [W-1:0]      rsp_data_reg;
  logic              rsp_zero_reg;

  logic grant0, grant1, accept, capture, rsp_done;

  // Grant only while idle; on a tie the port that did not win last time goes.
  // Gated by rst_n so the ready outputs read 0 throughout reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_reg == IDLE && rst_n) begin
      if (r0_valid && r1_valid) begin
        grant0 = last_grant_reg;
        grant1 = ~last_grant_reg;
      end else begin
        grant0 = r0_valid;
        grant1 = r1_valid;
      end
    end
  end

  assign accept   = grant0 | grant1;
  assign rsp_done = (state_reg == RESP) && (owner_reg ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = lat_cnt_reg;
    capture      = 1'b0;
    case (state_reg)
      IDLE: begin
        lat_cnt_next = '0;
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        if (lat_cnt_reg == LAT_LAST) begin
          capture      = 1'b1;
          lat_cnt_next = '0;
          state_next   = RESP;
        end else begin
          lat_cnt_next = lat_cnt_reg + 1'b1;
        end
      end
      RESP: begin
        if (rsp_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      d1_reg         <= '0;
      d2_reg         <= '0;
      imm_reg        <= '0;
      ctrl_reg       <= '0;
      rsp_data_reg   <= '0;
      rsp_zero_reg   <= 1'b0;
    end else begin
      if (accept) begin
        owner_reg      <= grant1;
        last_grant_reg <= grant1;
        d1_reg         <= grant1 ? r1_d1   : r0_d1;
        d2_reg         <= grant1 ? r1_d2   : r0_d2;
        imm_reg        <= grant1 ? r1_imm  : r0_imm;
        ctrl_reg       <= grant1 ? r1_ctrl : r0_ctrl;
      end
      if (capture) begin
        rsp_data_reg <= alu_result;
        rsp_zero_reg <= alu_zero;
      end
    end
  end

  assign r0_ready   = grant0;
  assign r1_ready   = grant1;
  assign rsp0_valid = (state_reg == RESP) && !owner_reg;
  assign rsp1_valid = (state_reg == RESP) && owner_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign alu_d1     = d1_reg;
  assign alu_d2     = d2_reg;
  assign alu_imm    = imm_reg;
  assign alu_ctrl   = ctrl_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_exec_arbiter.sv
// Bench for exec_arbiter: a timestamp-based transaction model checks the ALU_LAT=1 instance every cycle;
// a second ALU_LAT=3 instance gets directed checks on operand hold time and result latency.
module tb_exec_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] imm, input logic [4:0] c);
    case (c)
      5'b00000: return a & b;
      5'b00001: return a | b;
      5'b00010: return a + b;
      5'b00110: return a - b;
      5'b01000: return a << imm[4:0];
      default:  return a ^ b;
    endcase
  endfunction

  // ---------------- ALU_LAT = 1 instance ----------------
  logic        r0_valid = 0, r1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic        r0_ready, r1_ready, rsp0_valid, rsp1_valid, rsp_zero, busy, alu_zero;
  logic [31:0] r0_d1 = 0, r0_d2 = 0, r0_imm = 0, r1_d1 = 0, r1_d2 = 0, r1_imm = 0;
  logic [4:0]  r0_ctrl = 0, r1_ctrl = 0, alu_ctrl;
  logic [31:0] rsp_data, alu_d1, alu_d2, alu_imm, alu_result;

  assign alu_result = alu_fn(alu_d1, alu_d2, alu_imm, alu_ctrl);
  assign alu_zero   = (alu_result == 32'd0);

  exec_arbiter #(.W(32), .CTRL_W(5), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_d1(r0_d1), .r0_d2(r0_d2),
    .r0_imm(r0_imm), .r0_ctrl(r0_ctrl),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_d1(r1_d1), .r1_d2(r1_d2),
    .r1_imm(r1_imm), .r1_ctrl(r1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_imm(alu_imm), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // ---------------- ALU_LAT = 3 instance ----------------
  logic        t_r0_valid = 0, t_r1_valid = 0, t_rsp0_ready = 0, t_rsp1_ready = 0;
  logic        t_r0_ready, t_r1_ready, t_rsp0_valid, t_rsp1_valid, t_rsp_zero, t_busy, t_alu_zero;
  logic [31:0] t_r0_d1 = 0, t_r0_d2 = 0, t_r0_imm = 0, t_r1_d1 = 0, t_r1_d2 = 0, t_r1_imm = 0;
  logic [4:0]  t_r0_ctrl = 0, t_r1_ctrl = 0, t_alu_ctrl;
  logic [31:0] t_rsp_data, t_alu_d1, t_alu_d2, t_alu_imm, t_alu_result;

  assign t_alu_result = alu_fn(t_alu_d1, t_alu_d2, t_alu_imm, t_alu_ctrl);
  assign t_alu_zero   = (t_alu_result == 32'd0);

  exec_arbiter #(.W(32), .CTRL_W(5), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(t_r0_valid), .r0_ready(t_r0_ready), .r0_d1(t_r0_d1), .r0_d2(t_r0_d2),
    .r0_imm(t_r0_imm), .r0_ctrl(t_r0_ctrl),
    .r1_valid(t_r1_valid), .r1_ready(t_r1_ready), .r1_d1(t_r1_d1), .r1_d2(t_r1_d2),
    .r1_imm(t_r1_imm), .r1_ctrl(t_r1_ctrl),
    .rsp0_valid(t_rsp0_valid), .rsp0_ready(t_rsp0_ready),
    .rsp1_valid(t_rsp1_valid), .rsp1_ready(t_rsp1_ready),
    .rsp_data(t_rsp_data), .rsp_zero(t_rsp_zero),
    .alu_d1(t_alu_d1), .alu_d2(t_alu_d2), .alu_imm(t_alu_imm), .alu_ctrl(t_alu_ctrl),
    .alu_result(t_alu_result), .alu_zero(t_alu_zero), .busy(t_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got no handshake expected one within bound (cycle %0d)", nm, cyc);
  endtask

  // ---------------- transaction model (ALU_LAT = 1) ----------------
  // One transaction in flight at most; its result is due LAT+1 cycles after the accept cycle.
  localparam int LAT = 1;
  logic        m_pend = 0, m_own = 0, m_last = 1, m_zero = 0;
  int          m_due = 0;
  logic [31:0] m_d1 = 0, m_d2 = 0, m_imm = 0, m_res = 0;
  logic [4:0]  m_ctrl = 0;

  function automatic logic [1:0] pick(input logic pend, input logic last,
                                      input logic v0, input logic v1);
    if (pend) return 2'b00;
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    return {v1 & ~v0, v0};
  endfunction

  logic [1:0]  m_g;
  logic        m_e0, m_e1;
  logic [31:0] m_in_d1, m_in_d2, m_in_imm;
  logic [4:0]  m_in_ctrl;
  assign m_g       = pick(m_pend, m_last, r0_valid, r1_valid);
  assign m_e0      = m_pend && !m_own && (cyc >= m_due);
  assign m_e1      = m_pend && m_own && (cyc >= m_due);
  assign m_in_d1   = m_g[1] ? r1_d1 : r0_d1;
  assign m_in_d2   = m_g[1] ? r1_d2 : r0_d2;
  assign m_in_imm  = m_g[1] ? r1_imm : r0_imm;
  assign m_in_ctrl = m_g[1] ? r1_ctrl : r0_ctrl;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend <= 0; m_last <= 1; m_own <= 0;
      m_d1 <= 0; m_d2 <= 0; m_imm <= 0; m_ctrl <= 0;
    end else if (m_g != 2'b00) begin
      m_pend <= 1;
      m_own  <= m_g[1];
      m_last <= m_g[1];
      m_due  <= cyc + LAT + 1;
      m_d1   <= m_in_d1; m_d2 <= m_in_d2; m_imm <= m_in_imm; m_ctrl <= m_in_ctrl;
      m_res  <= alu_fn(m_in_d1, m_in_d2, m_in_imm, m_in_ctrl);
      m_zero <= (alu_fn(m_in_d1, m_in_d2, m_in_imm, m_in_ctrl) == 32'd0);
    end else if ((m_e0 && rsp0_ready) || (m_e1 && rsp1_ready)) begin
      m_pend <= 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_r0_ready", r0_ready, 0);     chk("rst_r1_ready", r1_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0); chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_busy", busy, 0);             chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_zero", rsp_zero, 0);     chk("rst_alu_d1", alu_d1, 0);
      chk("rst_alu_d2", alu_d2, 0);         chk("rst_alu_imm", alu_imm, 0);
      chk("rst_alu_ctrl", alu_ctrl, 0);
    end else begin
      chk("r0_ready", r0_ready, m_g[0]);    chk("r1_ready", r1_ready, m_g[1]);
      chk("rsp0_valid", rsp0_valid, m_e0);  chk("rsp1_valid", rsp1_valid, m_e1);
      chk("busy", busy, m_pend);
      chk("alu_d1", alu_d1, m_d1);          chk("alu_d2", alu_d2, m_d2);
      chk("alu_imm", alu_imm, m_imm);       chk("alu_ctrl", alu_ctrl, m_ctrl);
      if (m_e0 || m_e1) begin
        chk("rsp_data", rsp_data, m_res);
        chk("rsp_zero", rsp_zero, m_zero);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cyc(input int n);
    for (int i = 0; i < 100 && cyc < n; i++) step();
    @(negedge clk);
    #1;
  endtask

  // Hold the port's request until it is granted, then drop it after the accept edge.
  task automatic hold_until_ready(input int port, output int acc);
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((port == 0 && r0_ready) || (port == 1 && r1_ready)) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) timeout(port == 0 ? "r0_grant" : "r1_grant");
    step();
    if (port == 0) r0_valid = 0; else r1_valid = 0;
  endtask

  task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] c, output int acc);
    if (port == 0) begin
      r0_d1 = a; r0_d2 = b; r0_imm = imm; r0_ctrl = c; r0_valid = 1;
    end else begin
      r1_d1 = a; r1_d2 = b; r1_imm = imm; r1_ctrl = c; r1_valid = 1;
    end
    hold_until_ready(port, acc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  int a;
  int seq[4];
  int ns;

  initial begin
    // Reset state
    step(); step();
    chk("reset_busy", busy, 0);
    chk("reset_t_busy", t_busy, 0);
    step();
    rst_n = 1;
    step();

    // ALU_LAT=3: operands held three cycles, result at accept+4
    t_rsp0_ready = 1;
    t_r0_d1 = 100; t_r0_d2 = 23; t_r0_imm = 0; t_r0_ctrl = 5'b00010; t_r0_valid = 1;
    a = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (t_r0_ready) begin a = cyc; break; end
    end
    if (a < 0) timeout("t_r0_grant");
    step();
    t_r0_valid = 0;
    t_r0_d1 = 32'hDEAD;
    for (int k = 1; k <= 3; k++) begin
      at_cyc(a + k);
      chk("lat3_alu_d1", t_alu_d1, 100);
      chk("lat3_alu_d2", t_alu_d2, 23);
      chk("lat3_alu_imm", t_alu_imm, 0);
      chk("lat3_alu_ctrl", t_alu_ctrl, 5'b00010);
      chk("lat3_busy", t_busy, 1);
      chk("lat3_rsp0_early", t_rsp0_valid, 0);
    end
    at_cyc(a + 4);
    chk("lat3_rsp0_valid", t_rsp0_valid, 1);
    chk("lat3_rsp1_valid", t_rsp1_valid, 0);
    chk("lat3_data", t_rsp_data, 123);
    chk("lat3_zero", t_rsp_zero, 0);
    chk("lat3_r1_ready", t_r1_ready, 0);
    step();
    at_cyc(a + 5);
    chk("lat3_idle", t_busy, 0);
    step();

    // p0 add 5+3 -> rsp0 at accept+2, data 8
    rsp0_ready = 1; rsp1_ready = 1;
    issue(0, 5, 3, 0, 5'b00010, a);
    at_cyc(a + 1);
    chk("add_busy", busy, 1);
    chk("add_rsp0_early", rsp0_valid, 0);
    at_cyc(a + 2);
    chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_data", rsp_data, 8);
    chk("add_zero", rsp_zero, 0);
    step();

    // p1 sub 7-7 -> zero flag, only rsp1 valid
    issue(1, 7, 7, 0, 5'b00110, a);
    at_cyc(a + 2);
    chk("sub_rsp1_valid", rsp1_valid, 1);
    chk("sub_rsp0_valid", rsp0_valid, 0);
    chk("sub_data", rsp_data, 0);
    chk("sub_zero", rsp_zero, 1);
    step();

    // Both ports continuously valid: grants alternate starting with p0
    r0_d1 = 10; r0_d2 = 20; r0_ctrl = 5'b00010;
    r1_d1 = 9;  r1_d2 = 4;  r1_ctrl = 5'b00110;
    r0_valid = 1; r1_valid = 1;
    ns = 0;
    for (int i = 0; i < 40 && ns < 4; i++) begin
      @(negedge clk);
      if (r0_ready && r1_ready) chk("both_ready", {r0_ready, r1_ready}, 2'b10);
      if (r0_ready) begin seq[ns] = 0; ns = ns + 1; end
      else if (r1_ready) begin seq[ns] = 1; ns = ns + 1; end
      step();
    end
    r0_valid = 0; r1_valid = 0;
    chk("rr_count", ns, 4);
    chk("rr_g0", seq[0], 0);
    chk("rr_g1", seq[1], 1);
    chk("rr_g2", seq[2], 0);
    chk("rr_g3", seq[3], 1);
    for (int i = 0; i < 4; i++) step();

    // Owner backpressure: result held, p1 waits, non-owner rsp1_ready ignored
    rsp0_ready = 0; rsp1_ready = 1;
    issue(0, 32'h0F0F, 32'h00FF, 0, 5'b00001, a);
    r1_d1 = 1; r1_d2 = 2; r1_ctrl = 5'b00010; r1_valid = 1;
    for (int k = 0; k < 5; k++) begin
      at_cyc(a + 2 + k);
      chk("hold_rsp0_valid", rsp0_valid, 1);
      chk("hold_data", rsp_data, 32'h0FFF);
      chk("hold_busy", busy, 1);
      chk("hold_r1_ready", r1_ready, 0);
      chk("hold_rsp1_valid", rsp1_valid, 0);
    end
    rsp0_ready = 1;
    at_cyc(a + 7);
    chk("release_busy", busy, 0);
    chk("release_r1_ready", r1_ready, 1);
    step();
    r1_valid = 0;
    for (int i = 0; i < 4; i++) step();

    // Reset mid-EXEC, then p0 wins the first tie
    issue(0, 1, 1, 0, 5'b00010, a);
    r0_valid = 1; r1_valid = 1;
    rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_r0_ready", r0_ready, 0);
    chk("midrst_r1_ready", r1_ready, 0);
    chk("midrst_rsp0_valid", rsp0_valid, 0);
    chk("midrst_alu_d1", alu_d1, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    step(); step();
    rst_n = 1;
    #1;
    chk("postrst_r0_ready", r0_ready, 1);
    chk("postrst_r1_ready", r1_ready, 0);
    step();
    r0_valid = 0;
    hold_until_ready(1, a);
    for (int i = 0; i < 4; i++) step();
    chk("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
